// File: rtl/elevator_request_fsm.sv
// Single-car elevator request scheduler: latches floor calls, sweeps the car up/down
// one floor per TRAVEL_TICKS timer strobes and holds the door for DOOR_TICKS strobes.
module elevator_request_fsm #(
    parameter int unsigned TRAVEL_TICKS = 16,
    parameter int unsigned DOOR_TICKS   = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] call_req,
    input  logic       tick,
    output logic [7:0] destination,
    output logic [1:0] sim_state,
    output logic [2:0] current_floor,
    output logic       door_open
);

    typedef enum logic [1:0] {
        StIdle       = 2'b00,
        StMovingUp   = 2'b01,
        StMovingDown = 2'b10,
        StDoorOpen   = 2'b11
    } state_e;

    localparam logic [7:0] TravelLast = 8'(TRAVEL_TICKS - 1);
    localparam logic [7:0] DoorLast   = 8'(DOOR_TICKS - 1);

    state_e     r_state;
    state_e     w_state_next;
    logic [7:0] r_dest;
    logic [7:0] w_dest_next;
    logic [2:0] r_floor;
    logic [2:0] w_floor_next;
    logic [7:0] r_timer;
    logic [7:0] w_timer_next;
    logic       r_dir_up;
    logic       w_dir_up_next;
    logic       r_door_open;

    logic [7:0] w_req;
    logic [7:0] w_above_mask;
    logic [7:0] w_below_mask;
    logic       w_any_above;
    logic       w_any_below;
    logic [2:0] w_floor_up;
    logic [2:0] w_floor_down;
    logic [7:0] w_clear_mask;

    // Request vector: pending bitmap before this edge plus this cycle's calls.
    always_comb begin
        w_req        = r_dest | call_req;
        w_above_mask = '0;
        w_below_mask = '0;
        for (int i = 0; i < 8; i++) begin
            w_above_mask[i] = (3'(i) > r_floor);
            w_below_mask[i] = (3'(i) < r_floor);
        end
        w_any_above  = |(w_req & w_above_mask);
        w_any_below  = |(w_req & w_below_mask);
        w_floor_up   = r_floor + 3'd1;
        w_floor_down = r_floor - 3'd1;
    end

    always_comb begin
        w_state_next = r_state;
        w_floor_next = r_floor;
        w_timer_next = r_timer;

        unique case (r_state)
            StIdle: begin
                if (w_req[r_floor]) begin
                    w_state_next = StDoorOpen;
                end else if (w_any_above) begin
                    w_state_next = StMovingUp;
                end else if (w_any_below) begin
                    w_state_next = StMovingDown;
                end
            end

            StMovingUp: begin
                if (tick) begin
                    if (r_timer == TravelLast) begin
                        if (r_floor == 3'd7) begin
                            // Blocked at the top floor: never wrap.
                            w_state_next = w_req[r_floor] ? StDoorOpen : StIdle;
                        end else begin
                            w_floor_next = w_floor_up;
                            w_timer_next = '0;
                            if (w_req[w_floor_up]) begin
                                w_state_next = StDoorOpen;
                            end else if (w_floor_up == 3'd7) begin
                                w_state_next = StIdle;
                            end
                        end
                    end else begin
                        w_timer_next = r_timer + 8'd1;
                    end
                end
            end

            StMovingDown: begin
                if (tick) begin
                    if (r_timer == TravelLast) begin
                        if (r_floor == 3'd0) begin
                            w_state_next = w_req[r_floor] ? StDoorOpen : StIdle;
                        end else begin
                            w_floor_next = w_floor_down;
                            w_timer_next = '0;
                            if (w_req[w_floor_down]) begin
                                w_state_next = StDoorOpen;
                            end else if (w_floor_down == 3'd0) begin
                                w_state_next = StIdle;
                            end
                        end
                    end else begin
                        w_timer_next = r_timer + 8'd1;
                    end
                end
            end

            StDoorOpen: begin
                if (call_req[r_floor]) begin
                    // A call at this floor holds the door open.
                    w_timer_next = '0;
                end else if (tick) begin
                    if (r_timer == DoorLast) begin
                        if (r_dir_up && w_any_above) begin
                            w_state_next = StMovingUp;
                        end else if (w_any_below) begin
                            w_state_next = StMovingDown;
                        end else if (w_any_above) begin
                            w_state_next = StMovingUp;
                        end else begin
                            w_state_next = StIdle;
                        end
                    end else begin
                        w_timer_next = r_timer + 8'd1;
                    end
                end
            end

            default: begin
                w_state_next = StIdle;
            end
        endcase

        if (w_state_next != r_state) begin
            w_timer_next = '0;
        end
    end

    always_comb begin
        w_dir_up_next = r_dir_up;
        if (w_state_next == StMovingUp) begin
            w_dir_up_next = 1'b1;
        end else if (w_state_next == StMovingDown) begin
            w_dir_up_next = 1'b0;
        end
    end

    // The served floor is cleared on entry to, during, and on exit from the door phase.
    always_comb begin
        w_clear_mask = '0;
        if (r_state == StDoorOpen || w_state_next == StDoorOpen) begin
            w_clear_mask = 8'b1 << w_floor_next;
        end
        w_dest_next = (r_dest | call_req) & ~w_clear_mask;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_dest      <= '0;
            r_floor     <= '0;
            r_timer     <= '0;
            r_dir_up    <= 1'b1;
            r_door_open <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_dest      <= w_dest_next;
            r_floor     <= w_floor_next;
            r_timer     <= w_timer_next;
            r_dir_up    <= w_dir_up_next;
            r_door_open <= (w_state_next == StDoorOpen);
        end
    end

    assign destination   = r_dest;
    assign sim_state     = r_state;
    assign current_floor = r_floor;
    assign door_open     = r_door_open;

endmodule

// File: doc/elevator_request_fsm.md
ELEVATOR_REQUEST_FSM -- requirements
Module: elevator_request_fsm

Interface
REQ-001 Parameter TRAVEL_TICKS, default 16, tick strobes per one-floor move (legal range 1..255).
REQ-002 Parameter DOOR_TICKS, default 32, tick strobes the door stays open (legal range 1..255).
REQ-003 clk  input  1  single system clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 call_req  input  8  floor call buttons, bit i = floor i; sampled every clk edge, level or pulse.
REQ-006 tick  input  1  timer enable strobe; one-cycle pulses, any rate up to every cycle.
REQ-007 destination  output  8  registered pending-request bitmap; drives vgaController destination.
REQ-008 sim_state  output  2  registered state code; drives vgaController sim_state.
REQ-009 current_floor  output  3  registered car position, 0..7.
REQ-010 door_open  output  1  registered, high exactly when sim_state = DOOR_OPEN.

Function
REQ-011 States and codes: IDLE = 2'b00, MOVING_UP = 2'b01, MOVING_DOWN = 2'b10, DOOR_OPEN = 2'b11; sim_state shall equal the current state code.
REQ-012 Pending update each edge: destination <= (destination | call_req) & ~clear_mask; clear_mask is one-hot at current_floor on the edge that enters DOOR_OPEN, and one-hot at current_floor on every edge while in DOOR_OPEN, else zero.
REQ-013 A call_req bit asserted at edge N shall appear in destination after edge N (one-cycle latency), except the bit for current_floor while in or entering DOOR_OPEN, which shall never set.
REQ-014 Decisions shall use the value of destination from before the current edge, OR'ed with call_req (the "request vector").
REQ-015 IDLE: request vector bit at current_floor -> DOOR_OPEN; else any bit above current_floor -> MOVING_UP; else any bit below -> MOVING_DOWN; else stay IDLE; IDLE->DOOR_OPEN latency one edge.
REQ-016 An 8-bit internal timer shall clear to 0 on every state entry and increment only on edges where tick = 1 in MOVING_UP, MOVING_DOWN or DOOR_OPEN.
REQ-017 MOVING_UP: on the edge with tick = 1 and timer = TRAVEL_TICKS-1, current_floor increments by 1; if the request vector bit at the new floor is set, go to DOOR_OPEN, else remain MOVING_UP with timer cleared.
REQ-018 MOVING_DOWN: identical to REQ-017 with current_floor decrementing.
REQ-019 current_floor shall never wrap: increment blocked at 7, decrement blocked at 0; if reached with no request at that floor, go to IDLE.
REQ-020 DOOR_OPEN: on the edge with tick = 1 and timer = DOOR_TICKS-1, exit to: MOVING_UP if last direction was up and a request exists above; else MOVING_DOWN if a request exists below; else MOVING_UP if a request exists above; else IDLE.
REQ-021 A 1-bit last-direction register shall be set to up on entering MOVING_UP, down on entering MOVING_DOWN, and be unchanged otherwise.
REQ-022 A call at current_floor during DOOR_OPEN shall restart the door timer to 0 (door held open).
REQ-023 tick = 0 shall freeze all timers; no state leaves MOVING_* or DOOR_OPEN without tick.
REQ-024 Simultaneous call_req for current and other floors in IDLE: DOOR_OPEN wins; other bits stay pending.

Reset
REQ-025 While rst_n = 0: state IDLE, sim_state = 2'b00, destination = 8'h00, current_floor = 0, door_open = 0, timer = 0, last direction = up; asynchronous assert, release synchronous to next clk edge.
REQ-026 Reset asserted mid-move or mid-door shall discard all pending requests; no residual state after release.

Verification
REQ-027 Reset, tick=1 every cycle, call_req=8'h20 one cycle -> destination=8'h20 next cycle, sim_state=01, floor advances every 16 cycles, at floor 5 sim_state=11, door_open=1, destination=8'h00.
REQ-028 At floor 0 IDLE, call_req=8'h01 -> next edge sim_state=11, destination stays 8'h00; after 32 ticks sim_state=00.
REQ-029 Car moving up from 2 to 6 (destination=8'h40), inject call_req=8'h02 -> car serves 6 first, then DOOR_OPEN exits to MOVING_DOWN, serves floor 1, ends IDLE, destination=8'h00.
REQ-030 DOOR_OPEN at floor 3, hold call_req=8'h08 for 40 cycles -> door stays open the whole time, closes 32 ticks after release.
REQ-031 tick held 0 while MOVING_UP -> current_floor and sim_state frozen indefinitely; resume on tick.
REQ-032 Assert rst_n=0 asynchronously at floor 4 mid-move with destination=8'h81 -> outputs immediately 00/8'h00/0/0, IDLE after release.
